// File: rtl/mem_load_store_unit.sv
`timescale 1ns/1ps
// MEM-stage load/store sequencer: byte or byte-pair accesses over a req/ack
// data-memory port, stalling the pipeline until the access completes.
// Ports: clock/reset_n; op_* + st_data_* from EX/MEM; mem_* memory port;
// ld_res_top/ld_res_bot/ld_valid to MEM/WB; stall to IF..EX/MEM; bus_fault.
// Option: define LSU_ACK_TIMEOUT_EN to abort accesses whose ack never comes
// (limit TIMEOUT_CYCLES); otherwise the unit waits forever, bus_fault = 0.
module mem_load_store_unit #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  op_valid,
  input  logic                  op_write,
  input  logic                  op_pair,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [7:0]            st_data_top,
  input  logic [7:0]            st_data_bot,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            ld_res_top,
  output logic [7:0]            ld_res_bot,
  output logic                  ld_valid,
  output logic                  stall,
  output logic                  bus_fault
);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic                  pair_q, pair_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            top_q, top_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            res_top_q, res_top_d;
  logic [7:0]            res_bot_q, res_bot_d;

`ifdef LSU_ACK_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;
  logic       expired;
  // Abort on the edge that completes the TO_LIM-th unacked wait cycle.
  assign expired = (8'(cnt_q + 8'd1) == TO_LIM);
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    pair_d    = pair_q;
    addr_d    = addr_q;
    top_d     = top_q;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    res_top_d = res_top_q;
    res_bot_d = res_bot_q;
`ifdef LSU_ACK_TIMEOUT_EN
    cnt_d     = cnt_q;
    fault_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          wr_d    = op_write;
          pair_d  = op_pair;
          addr_d  = op_addr;
          top_d   = st_data_top;
          req_d   = 1'b1;
          we_d    = op_write;
          maddr_d = op_addr;
          wdata_d = st_data_bot;
          state_d = BYTE0;
`ifdef LSU_ACK_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      BYTE0: begin
        if (mem_ack) begin
          if (!wr_q) res_bot_d = mem_rdata;
          if (pair_q) begin
            state_d = BYTE1;
            maddr_d = addr_q + ADDR_WIDTH'(1);
            wdata_d = top_q;
`ifdef LSU_ACK_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end else begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
          end
        end
`ifdef LSU_ACK_TIMEOUT_EN
        else if (expired) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          fault_d = 1'b1;
          if (!wr_q) begin
            res_bot_d = 8'hFF;
            if (pair_q) res_top_d = 8'hFF;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      BYTE1: begin
        if (mem_ack) begin
          if (!wr_q) res_top_d = mem_rdata;
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
`ifdef LSU_ACK_TIMEOUT_EN
        else if (expired) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          fault_d = 1'b1;
          if (!wr_q) res_top_d = 8'hFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      pair_q    <= 1'b0;
      addr_q    <= '0;
      top_q     <= 8'h00;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= 8'h00;
      res_top_q <= 8'h00;
      res_bot_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      pair_q    <= pair_d;
      addr_q    <= addr_d;
      top_q     <= top_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      res_top_q <= res_top_d;
      res_bot_q <= res_bot_d;
    end
  end

`ifdef LSU_ACK_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign bus_fault = fault_q;
`else
  assign bus_fault = 1'b0;
`endif

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign ld_res_top = res_top_q;
  assign ld_res_bot = res_bot_q;
  assign ld_valid   = (state_q == DONE) && !wr_q;
  assign stall      = op_valid && (state_q != DONE);

endmodule

// File: tb/tb_mem_load_store_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_load_store_unit: randomized byte/pair loads and
// stores against a memory responder, checked by a decoupled monitor.
module tb_mem_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_write = 1'b0;
  logic        op_pair = 1'b0;
  logic [15:0] op_addr = 16'h0;
  logic [7:0]  st_data_top = 8'h0;
  logic [7:0]  st_data_bot = 8'h0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b1;
  logic [7:0]  mem_rdata = 8'h0;
  logic [7:0]  ld_res_top, ld_res_bot;
  logic        ld_valid, stall, bus_fault;

  always #5 clock = ~clock;

  mem_load_store_unit #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .op_valid(op_valid), .op_write(op_write), .op_pair(op_pair),
    .op_addr(op_addr), .st_data_top(st_data_top), .st_data_bot(st_data_bot),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_res_top(ld_res_top), .ld_res_bot(ld_res_bot),
    .ld_valid(ld_valid), .stall(stall), .bus_fault(bus_fault)
  );

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } xfer_t;

  int          n_vec = 0;
  int          n_err = 0;
  xfer_t       exp_x[$];
  logic [15:0] exp_ld[$];
  logic [7:0]  rsp_mem[logic [15:0]];
  logic [7:0]  mdl_mem[logic [15:0]];
  logic [7:0]  res_top = 8'h0;
  logic [7:0]  res_bot = 8'h0;
  int          force_wait = -1;
  int          wait_acc = 0;
  bit          noack = 0;
  bit          rsp_en = 0;
  bit          fault_ok = 0;

  function automatic logic [7:0] seed_b(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [15:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : seed_b(a);
  endfunction

  function automatic logic [7:0] rsp_rd(input logic [15:0] a);
    return rsp_mem.exists(a) ? rsp_mem[a] : seed_b(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: random or forced wait, then a one-cycle ack.
  initial begin
    int wl;
    wl = -1;
    forever begin
      @(posedge clock); #1;
      if (!rsp_en) begin
        mem_ack = 1'b1;
        continue;
      end
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (!reset_n || noack) begin
        wl = -1;
        continue;
      end
      if (!mem_req) begin
        wl = -1;
        mem_ack = ($urandom_range(0, 3) == 0);
        continue;
      end
      if (wl < 0) begin
        wl = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        wait_acc += wl;
      end
      if (wl == 0) begin
        mem_ack = 1'b1;
        if (mem_we) rsp_mem[mem_addr] = mem_wdata;
        else mem_rdata = rsp_rd(mem_addr);
        wl = -1;
      end else begin
        wl--;
      end
    end
  end

  // Monitor: pops expected transfers and load results as the DUT shows them.
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = 16'h0;
  logic [7:0]  p_wdata = 8'h0;
  always @(negedge clock) begin
    xfer_t       x;
    logic [15:0] r;
    if (reset_n) begin
      if (mem_req && p_req && !p_ack) begin
        chk("req_stable_addr", mem_addr, p_addr);
        chk("req_stable_we", mem_we, p_we);
        chk("req_stable_wdata", mem_wdata, p_wdata);
      end
      if (mem_req && mem_ack) begin
        chk("xfer_expected", exp_x.size() != 0, 1);
        if (exp_x.size() != 0) begin
          x = exp_x.pop_front();
          chk("mem_we", mem_we, x.we);
          chk("mem_addr", mem_addr, x.addr);
          if (x.we) chk("mem_wdata", mem_wdata, x.wdata);
        end
      end
      if (ld_valid) begin
        chk("ld_expected", exp_ld.size() != 0, 1);
        if (exp_ld.size() != 0) begin
          r = exp_ld.pop_front();
          chk("ld_res", {ld_res_top, ld_res_bot}, r);
        end
      end
      if (bus_fault && !fault_ok) chk("bus_fault_stray", bus_fault, 0);
      p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
      p_addr = mem_addr; p_wdata = mem_wdata;
    end else begin
      p_req = 1'b0;
    end
  end

  task automatic apply(input bit w, input bit p, input logic [15:0] a,
                       input logic [7:0] t, input logic [7:0] b,
                       input bit track);
    logic [15:0] a1;
    a1 = a + 16'd1;
    op_valid = 1'b1; op_write = w; op_pair = p; op_addr = a;
    st_data_top = t; st_data_bot = b;
    wait_acc = 0;
    if (!track) return;
    if (w) begin
      exp_x.push_back('{1'b1, a, b});
      mdl_mem[a] = b;
      if (p) begin
        exp_x.push_back('{1'b1, a1, t});
        mdl_mem[a1] = t;
      end
    end else begin
      exp_x.push_back('{1'b0, a, 8'h00});
      res_bot = mdl_rd(a);
      if (p) begin
        exp_x.push_back('{1'b0, a1, 8'h00});
        res_top = mdl_rd(a1);
      end
      exp_ld.push_back({res_top, res_bot});
    end
  endtask

  // Runs from the IDLE cycle to the DONE cycle, scrambling op_* after capture.
  task automatic finish_op(input int base, input bit w, input bit flt,
                           input logic [15:0] a);
    int cnt;
    bit done;
    cnt = 0; done = 0;
    @(negedge clock);
    if (stall) cnt++;
    @(posedge clock); #1;
    chk("req_after_capture", mem_req, 1);
    chk("addr_after_capture", mem_addr, a);
    chk("we_after_capture", mem_we, w);
    op_write = 1'($urandom); op_pair = 1'($urandom);
    op_addr = 16'($urandom);
    st_data_top = 8'($urandom); st_data_bot = 8'($urandom);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (stall) cnt++;
      else done = 1;
    end
    chk("op_completes", done, 1);
    chk("stall_cycles", cnt, base + wait_acc);
    chk("ld_valid_done", ld_valid, !w);
    chk("bus_fault_done", bus_fault, flt);
    chk("res_top", ld_res_top, res_top);
    chk("res_bot", ld_res_bot, res_bot);
  endtask

  initial begin
    bit          w, p;
    bit          done;
    int          cnt;
    logic [15:0] a;

    op_valid = 1'b1; op_write = 1'b0; op_addr = 16'h0042;
    repeat (2) @(negedge clock);
    chk("rst_ack_held", mem_ack, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_res_top", ld_res_top, 0);
    chk("rst_res_bot", ld_res_bot, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_bus_fault", bus_fault, 0);
    chk("rst_stall", stall, 1);
    @(posedge clock); #1;
    rsp_en = 1;
    @(posedge clock); #1;
    apply(0, 0, 16'h0042, 8'h00, 8'h00, 1);
    reset_n = 1'b1;
    finish_op(2, 0, 0, 16'h0042);

    force_wait = 0;
    @(posedge clock); #1;
    apply(1, 1, 16'hFFFF, 8'hBE, 8'hEF, 1);
    finish_op(3, 1, 0, 16'hFFFF);

    rsp_mem[16'h0100] = 8'h11; mdl_mem[16'h0100] = 8'h11;
    rsp_mem[16'h0101] = 8'h22; mdl_mem[16'h0101] = 8'h22;
    @(posedge clock); #1;
    apply(0, 1, 16'h0100, 8'h00, 8'h00, 1);
    finish_op(3, 0, 0, 16'h0100);

    force_wait = 2;
    rsp_mem[16'h1234] = 8'h5A; mdl_mem[16'h1234] = 8'h5A;
    @(posedge clock); #1;
    apply(0, 0, 16'h1234, 8'h00, 8'h00, 1);
    finish_op(2, 0, 0, 16'h1234);

    force_wait = 1;
    @(posedge clock); #1;
    apply(0, 0, 16'h2000, 8'h00, 8'h00, 1);
    @(negedge clock);
    @(posedge clock); #1;
    op_valid = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      chk("stall_flush", stall, 0);
      if (ld_valid) done = 1;
    end
    chk("flush_completes", done, 1);
    chk("flush_res_bot", ld_res_bot, res_bot);

    force_wait = -1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
        op_valid = 1'b0;
        @(negedge clock);
        chk("stall_idle", stall, 0);
      end
      w = 1'($urandom); p = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = 16'($urandom);
        1: a = 16'hFFFF;
        2: a = 16'h0300 + 16'($urandom_range(0, 7));
        default: a = 16'hFFFE;
      endcase
      @(posedge clock); #1;
      apply(w, p, a, 8'($urandom), 8'($urandom), 1);
      finish_op(2 + int'(p), w, 0, a);
    end

    noack = 1;
    @(posedge clock); #1;
    apply(0, 1, 16'h4000, 8'h00, 8'h00, 0);
`ifdef LSU_ACK_TIMEOUT_EN
    res_top = 8'hFF; res_bot = 8'hFF;
    exp_ld.push_back(16'hFFFF);
    fault_ok = 1;
    finish_op(5, 0, 1, 16'h4000);
    fault_ok = 0;
    noack = 0;
    @(negedge clock);
    chk("bus_fault_one_cycle", bus_fault, 0);
`else
    @(negedge clock);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (stall && mem_req) cnt++;
    end
    chk("noack_stall_held", cnt, 20);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_req_drop", mem_req, 0);
    chk("async_rst_stall", stall, 1);
    op_valid = 1'b0;
    noack = 0;
    res_top = 8'h00; res_bot = 8'h00;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_res", {ld_res_top, ld_res_bot}, 16'h0000);
`endif

    @(posedge clock); #1;
    apply(0, 1, 16'hFFFF, 8'h00, 8'h00, 1);
    finish_op(2 + 1, 0, 0, 16'hFFFF);

    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("xfer_queue_empty", exp_x.size(), 0);
    chk("ld_queue_empty", exp_ld.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_load_store_unit.md
# mem_load_store_unit

Byte-wide data-memory access sequencer for the MEM stage. It accepts the memory operation held in EX/MEM, which is either a single byte or a byte pair. It runs a req/ack handshake with data memory and stalls the pipeline until the access completes. Load results appear on `ld_res_top`/`ld_res_bot`, which feed the `ld_res` inputs of the MEM/WB data input multiplexer.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: data-memory address width.
- `TIMEOUT_CYCLES`, default 255, range 1..255: ack wait limit. Used only with `LSU_ACK_TIMEOUT_EN`.

Ports:
- `clock` input 1: single clock. All state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `op_valid` input 1: EX/MEM holds a memory operation.
- `op_write` input 1: 1 = store, 0 = load.
- `op_pair` input 1: 1 = two-byte access (addr, addr+1); 0 = single byte at addr.
- `op_addr` input ADDR_WIDTH: byte address.
- `st_data_top` input 8: store data for addr+1 (pair only).
- `st_data_bot` input 8: store data for addr.
- `mem_req` output 1: memory request.
- `mem_we` output 1: write enable qualifying `mem_req`.
- `mem_addr` output ADDR_WIDTH: request address.
- `mem_wdata` output 8: write data.
- `mem_ack` input 1: memory completion. On a load, `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 8: read data.
- `ld_res_top` output 8: byte read from addr+1 (pair loads).
- `ld_res_bot` output 8: byte read from addr.
- `ld_valid` output 1: one-cycle pulse when a load completes.
- `stall` output 1: hold IF..EX/MEM this cycle.
- `bus_fault` output 1: one-cycle pulse on ack timeout.

## Operation
- FSM states: IDLE, BYTE0, BYTE1, DONE.
- IDLE:
  - When `op_valid` is 1, capture `op_write`, `op_pair`, `op_addr`, `st_data_*` into internal registers and go to BYTE0.
  - `mem_req` rises on that edge; `mem_addr` = addr, `mem_wdata` = `st_data_bot`.
- BYTE0: on the edge `mem_ack` is 1:
  - A load writes `mem_rdata` into the bot result register.
  - If the op is a pair, go to BYTE1 with `mem_addr` = addr+1 and `mem_wdata` = `st_data_top`. Otherwise go to DONE.
- BYTE1: on ack, a load writes the top result register; go to DONE.
- DONE:
  - `mem_req` is 0.
  - `ld_valid` is 1 for a load, 0 for a store.
  - Return to IDLE on the next edge.
- Results:
  - Single-byte loads update only `ld_res_bot`; `ld_res_top` keeps its old value.
  - Stores never alter `ld_res_*`.
  - `ld_res_*` hold their value until the next load writes them.
- `stall` = `op_valid` & (state != DONE). It is combinational from state and `op_valid`.
- Address arithmetic: addr+1 wraps modulo 2^ADDR_WIDTH, so 0xFFFF pairs with 0x0000.
- Signals ignored while not in IDLE: changes on `op_*`/`st_data_*`, and `op_valid` falling (flush). The captured operation always completes.
- `mem_ack` while `mem_req` = 0 is ignored.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `ld_valid`, `bus_fault` = 0; `mem_addr`, `mem_wdata`, `ld_res_top`, `ld_res_bot` = 0.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered. They stay stable from request until the acking edge.
- Single byte with zero-wait ack takes 3 cycles: IDLE (stall), BYTE0 (stall, ack), DONE (no stall).
- Pair with zero-wait acks takes 4 cycles. Each wait cycle on ack adds one cycle.
- `ld_res_*` are valid in the DONE cycle, in time for the MEM/WB capture edge, and remain valid afterward.
- Async reset mid-operation: `mem_req` drops immediately and the FSM returns to IDLE. A byte already acked stays written; there is no rollback.

## Configuration
- `LSU_ACK_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears at each request and counts cycles in BYTE0/BYTE1 without ack.
  - When the count reaches `TIMEOUT_CYCLES`, the access aborts to DONE and `bus_fault` pulses for one cycle.
  - A load loads 0xFF into every result byte not yet read.
  - A store drops its remaining bytes.
- Not defined: no counter; the FSM waits for ack indefinitely; `bus_fault` is tied to 0.

## Test plan
- Reset: assert `reset_n` = 0 with `op_valid` = 1 and `mem_ack` = 1. Required: all outputs at reset values, `stall` = 1, no request. After release, a request issues on the first edge.
- Single load: addr 0x1234, ack with 0x5A after 2 wait cycles. Required:
  - `mem_addr` = 0x1234 and `mem_we` = 0 throughout.
  - `stall` = 1 for 4 cycles.
  - `ld_valid` pulses once with `ld_res_bot` = 0x5A; `ld_res_top` unchanged.
- Pair store at 0xFFFF: top 0xBE, bot 0xEF, zero-wait acks. Required:
  - Writes of 0xEF at 0xFFFF, then 0xBE at 0x0000.
  - `ld_valid` stays 0 and `ld_res_*` are unchanged.
- Pair load, zero-wait, rdata 0x11 then 0x22. Required: `ld_res_bot` = 0x11, `ld_res_top` = 0x22, 4-cycle operation, stall low only in DONE.
- Flush: drop `op_valid` while in BYTE0. Required: the access still completes, and `stall` = 0 while `op_valid` = 0.
- With `LSU_ACK_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4: never ack a pair load. Required: abort after 4 wait cycles, `bus_fault` and `ld_valid` pulse, `ld_res_*` = 0xFF/0xFF. Without the macro, the same stimulus holds `stall` = 1 indefinitely.
